// File: rtl/eth_tx_pkg.sv
// rtl/eth_tx_pkg.sv - shared types, protocol constants and CRC-32 step for the Ethernet TX path
package eth_tx_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CSUM,
        PREAMBLE,
        SFD,
        ETH_HDR,
        IP_HDR,
        UDP_HDR,
        PAYLOAD,
        PAD,
        FCS,
        IFG
    } tx_state_t;

    localparam logic [15:0] ETHERTYPE_IPV4    = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP      = 8'h11;
    localparam logic [7:0]  PREAMBLE_BYTE     = 8'h55;
    localparam logic [7:0]  SFD_BYTE          = 8'hD5;
    localparam int          MIN_PAYLOAD_BYTES = 18;
    localparam logic [31:0] CRC_INIT          = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY_REFL     = 32'hEDB88320;

    // One bit of the reflected CRC-32 shift, bits taken LSB first off the wire.
    function automatic logic [31:0] crc32_bit(input logic [31:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return (c >> 1) ^ (fb ? CRC_POLY_REFL : 32'h0);
    endfunction

endpackage

// File: rtl/crc32_dibit.sv
// rtl/crc32_dibit.sv - reflected CRC-32 accumulator consuming one RMII dibit per cycle
module crc32_dibit
    import eth_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [1:0]  dibit,
    input  logic        valid,
    output logic [31:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc <= CRC_INIT;
        end else if (valid) begin
            crc <= crc32_bit(crc32_bit(crc, dibit[0]), dibit[1]);
        end
    end

endmodule

// File: rtl/network_stack_tx.sv
// rtl/network_stack_tx.sv - Ethernet II / IPv4 / UDP frame builder driving the RMII transmit pins
module network_stack_tx
    import eth_tx_pkg::*;
#(
    parameter int         N          = 2,
    parameter int         MAX_WORDS  = 736,
    parameter logic [7:0] TTL        = 8'h40,
    parameter int         IFG_CYCLES = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [10:0]  payload_words,
    input  logic [47:0]  src_mac,
    input  logic [47:0]  dst_mac,
    input  logic [31:0]  src_ip,
    input  logic [31:0]  dst_ip,
    input  logic [15:0]  src_port,
    input  logic [15:0]  dst_port,
    input  logic [15:0]  axiid,
    input  logic         axiiv,
    output logic         axiir,
    output logic [N-1:0] eth_txd,
    output logic         eth_txen,
    output logic         busy,
    output logic         done,
    output logic         underrun
);

    localparam logic [10:0] MAX_W    = 11'(MAX_WORDS);
    localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD_BYTES);
    localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);

    tx_state_t    state, state_next;
    logic [10:0]  cnt;
    logic [1:0]   dib;
    logic [10:0]  len_q;
    logic [4:0]   pad_q;
    logic [15:0]  ip_id;
    logic [47:0]  src_mac_q, dst_mac_q;
    logic [31:0]  src_ip_q, dst_ip_q;
    logic [15:0]  src_port_q, dst_port_q;
    logic [19:0]  csum_acc, csum_sum;
    logic [16:0]  fold1;
    logic [15:0]  fold2, ip_csum;
    logic [335:0] hdr;
    logic [15:0]  word_q;
    logic [31:0]  crc, fcs;
    logic [10:0]  words_clamped, len_next, sec_len;
    logic [15:0]  total_len, udp_len;
    logic         accept, is_byte, byte_last, sec_last;
    logic [7:0]   cur_byte;
    logic [1:0]   txd;

    assign accept        = (state == IDLE) && start;
    assign words_clamped = (payload_words > MAX_W) ? MAX_W : payload_words;
    assign len_next      = 11'({words_clamped, 1'b0});
    assign total_len     = 16'd28 + {5'd0, len_q};
    assign udp_len       = 16'd8 + {5'd0, len_q};

    assign is_byte   = state inside {PREAMBLE, SFD, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD, FCS};
    assign byte_last = (dib == 2'd3);
    assign sec_last  = byte_last && (cnt == sec_len - 11'd1);

    // Header sum is registered in the first CSUM cycle and folded in the second.
    assign csum_sum = 20'h04500 + 20'(total_len) + 20'(ip_id) + 20'h04000
                    + 20'({TTL, IP_PROTO_UDP})
                    + 20'(src_ip_q[31:16]) + 20'(src_ip_q[15:0])
                    + 20'(dst_ip_q[31:16]) + 20'(dst_ip_q[15:0]);
    assign fold1    = {1'b0, csum_acc[15:0]} + {13'd0, csum_acc[19:16]};
    assign fold2    = fold1[15:0] + {15'd0, fold1[16]};
    assign ip_csum  = ~fold2;
    assign fcs      = ~crc;

    always_comb begin
        sec_len = 11'd1;
        case (state)
            PREAMBLE: sec_len = 11'd7;
            SFD:      sec_len = 11'd1;
            ETH_HDR:  sec_len = 11'd14;
            IP_HDR:   sec_len = 11'd20;
            UDP_HDR:  sec_len = 11'd8;
            PAYLOAD:  sec_len = len_q;
            PAD:      sec_len = {6'd0, pad_q};
            FCS:      sec_len = 11'd4;
            default:  sec_len = 11'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = CSUM;
            CSUM:     if (cnt[0]) state_next = PREAMBLE;
            PREAMBLE: if (sec_last) state_next = SFD;
            SFD:      if (sec_last) state_next = ETH_HDR;
            ETH_HDR:  if (sec_last) state_next = IP_HDR;
            IP_HDR:   if (sec_last) state_next = UDP_HDR;
            UDP_HDR:  if (sec_last) state_next = (len_q != 11'd0) ? PAYLOAD : PAD;
            PAYLOAD:  if (sec_last) state_next = (pad_q != 5'd0) ? PAD : FCS;
            PAD:      if (sec_last) state_next = FCS;
            FCS:      if (sec_last) state_next = IFG;
            IFG:      if (cnt == IFG_LAST) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 11'd0;
            dib      <= 2'd0;
            ip_id    <= 16'd0;
            underrun <= 1'b0;
        end else begin
            if (state_next != state) begin
                cnt <= 11'd0;
                dib <= 2'd0;
            end else if (is_byte) begin
                dib <= dib + 2'd1;
                if (byte_last) cnt <= cnt + 11'd1;
            end else begin
                cnt <= cnt + 11'd1;
            end
            if (accept) underrun <= 1'b0;
            else if (axiir && !axiiv) underrun <= 1'b1;
            if (done) ip_id <= ip_id + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            src_mac_q  <= src_mac;
            dst_mac_q  <= dst_mac;
            src_ip_q   <= src_ip;
            dst_ip_q   <= dst_ip;
            src_port_q <= src_port;
            dst_port_q <= dst_port;
            len_q      <= len_next;
            pad_q      <= (len_next < MIN_LEN) ? 5'(MIN_LEN - len_next) : 5'd0;
        end
        if (state == CSUM && !cnt[0]) csum_acc <= csum_sum;
        // The 42 header bytes leave MSB-first from the top of this register.
        if (state == CSUM && cnt[0]) begin
            hdr <= {dst_mac_q, src_mac_q, ETHERTYPE_IPV4,
                    8'h45, 8'h00, total_len, ip_id, 16'h4000, TTL, IP_PROTO_UDP, ip_csum,
                    src_ip_q, dst_ip_q,
                    src_port_q, dst_port_q, udp_len, 16'h0000};
        end else if (byte_last && (state inside {ETH_HDR, IP_HDR, UDP_HDR})) begin
            hdr <= {hdr[327:0], 8'h00};
        end
        if (axiir) word_q <= axiiv ? axiid : 16'h0000;
    end

    always_comb begin
        cur_byte = 8'h00;
        case (state)
            PREAMBLE: cur_byte = PREAMBLE_BYTE;
            SFD:      cur_byte = SFD_BYTE;
            ETH_HDR, IP_HDR, UDP_HDR: cur_byte = hdr[335:328];
            PAYLOAD:  cur_byte = cnt[0] ? word_q[7:0] : word_q[15:8];
            FCS: begin
                case (cnt[1:0])
                    2'd0:    cur_byte = fcs[7:0];
                    2'd1:    cur_byte = fcs[15:8];
                    2'd2:    cur_byte = fcs[23:16];
                    default: cur_byte = fcs[31:24];
                endcase
            end
            default:  cur_byte = 8'h00;
        endcase
    end

    assign txd      = is_byte ? cur_byte[{dib, 1'b0} +: 2] : 2'b00;
    assign eth_txd  = txd;
    assign eth_txen = is_byte;
    assign busy     = (state != IDLE);
    assign done     = (state == IFG) && (cnt == IFG_LAST);
    // Word k is fetched in the cycle before its first dibit; word 0's fetch is the last header dibit.
    assign axiir    = ((state == UDP_HDR) && sec_last && (len_q != 11'd0))
                   || ((state == PAYLOAD) && byte_last && cnt[0] && (cnt + 11'd1 != len_q));

    crc32_dibit u_crc (
        .clk   (clk),
        .rst   (rst),
        .clear (state == CSUM),
        .dibit (txd),
        .valid (state inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD}),
        .crc   (crc)
    );

endmodule

// File: tb/tb_network_stack_tx.sv
// tb/tb_network_stack_tx.sv - self-checking bench for network_stack_tx against a byte-level frame model
module tb_network_stack_tx;

    localparam int IFG_CYCLES = 48;

    logic        clk = 1'b0;
    logic        rst, start, axiiv;
    logic [10:0] payload_words;
    logic [47:0] src_mac, dst_mac;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] src_port, dst_port, axiid;
    logic        axiir, eth_txen, busy, done, underrun;
    logic [1:0]  eth_txd;

    always #10 clk = ~clk;

    network_stack_tx dut (
        .clk(clk), .rst(rst), .start(start), .payload_words(payload_words),
        .src_mac(src_mac), .dst_mac(dst_mac), .src_ip(src_ip), .dst_ip(dst_ip),
        .src_port(src_port), .dst_port(dst_port), .axiid(axiid), .axiiv(axiiv),
        .axiir(axiir), .eth_txd(eth_txd), .eth_txen(eth_txen), .busy(busy),
        .done(done), .underrun(underrun)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_id;
    logic [15:0] wq[$];
    bit          wv[$];
    logic [7:0]  fb[$];
    logic [1:0]  ed[$];
    logic [1:0]  cap[$];
    logic [7:0]  rb[$];
    int          req_pos[$];
    int txen_first, txen_last, txen_cnt, done_cyc, idle_txd_bad, busy_low, ur_at_start;
    int gap_waited, gap_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] field16(input int off);
        if (9 + off < rb.size()) return {rb[8 + off], rb[9 + off]};
        return 16'hxxxx;
    endfunction

    // Frame built from the protocol rules: fields, 60-byte minimum, bytewise CRC.
    task automatic build_model(input int nw);
        logic [15:0] hw[10];
        int          sum, len;
        logic [31:0] c;
        len = 2 * nw;
        fb.delete();
        for (int i = 5; i >= 0; i--) fb.push_back(dst_mac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fb.push_back(src_mac[8*i +: 8]);
        fb.push_back(8'h08); fb.push_back(8'h00);
        hw[0] = 16'h4500;       hw[1] = 16'(28 + len); hw[2] = exp_id;
        hw[3] = 16'h4000;       hw[4] = 16'h4011;      hw[5] = 16'h0000;
        hw[6] = src_ip[31:16];  hw[7] = src_ip[15:0];
        hw[8] = dst_ip[31:16];  hw[9] = dst_ip[15:0];
        sum = 0;
        for (int i = 0; i < 10; i++) sum += int'(hw[i]);
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        hw[5] = ~sum[15:0];
        for (int i = 0; i < 10; i++) begin fb.push_back(hw[i][15:8]); fb.push_back(hw[i][7:0]); end
        fb.push_back(src_port[15:8]); fb.push_back(src_port[7:0]);
        fb.push_back(dst_port[15:8]); fb.push_back(dst_port[7:0]);
        fb.push_back(8'((8 + len) >> 8)); fb.push_back(8'(8 + len));
        fb.push_back(8'h00); fb.push_back(8'h00);
        for (int k = 0; k < nw; k++) begin
            fb.push_back(wv[k] ? wq[k][15:8] : 8'h00);
            fb.push_back(wv[k] ? wq[k][7:0] : 8'h00);
        end
        while (fb.size() < 60) fb.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (fb[i]) begin
            c = c ^ {24'd0, fb[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
        ed.delete();
        for (int i = 0; i < 8 + fb.size(); i++) begin
            logic [7:0] bt;
            bt = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : fb[i - 8];
            for (int d = 0; d < 4; d++) ed.push_back(bt[2*d +: 2]);
        end
    endtask

    task automatic run_frame(input logic [10:0] pw, input int bad_idx, input bit hold, input int rst_at);
        int nw, cyc, k;
        bit pend, fin;
        nw = (pw > 11'd736) ? 736 : int'(pw);
        wq.delete(); wv.delete();
        for (int i = 0; i < nw; i++) begin
            wq.push_back(16'($urandom_range(1, 65535)));
            wv.push_back(i != bad_idx);
        end
        cap.delete(); req_pos.delete();
        txen_first = -1; txen_last = -1; txen_cnt = 0; done_cyc = -1;
        idle_txd_bad = 0; busy_low = 0; ur_at_start = -1; gap_waited = 0; gap_busy = -1;
        if (busy) begin
            @(negedge clk);
            gap_waited = 1;
            gap_busy = int'(busy);
        end
        build_model(nw);
        payload_words = pw;
        start = 1'b1;
        k = 0; pend = 0; fin = 0; cyc = 0;
        axiid = (nw > 0) ? wq[0] : 16'h0;
        axiiv = (nw > 0) ? wv[0] : 1'b1;
        while (!fin && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            if (cyc == 1) ur_at_start = int'(underrun);
            if (!busy) busy_low++;
            if (pend) begin
                k++; pend = 0;
                axiid = (k < nw) ? wq[k] : 16'h0;
                axiiv = (k < nw) ? wv[k] : 1'b1;
            end
            if (eth_txen) begin
                if (txen_first < 0) txen_first = cyc;
                txen_last = cyc;
                txen_cnt++;
                cap.push_back(eth_txd);
            end else if (eth_txd != 2'b00) begin
                idle_txd_bad++;
            end
            if (axiir) begin
                pend = 1;
                req_pos.push_back(cyc - txen_first);
            end
            if (rst_at >= 0 && txen_cnt == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_mid_txen", eth_txen, 1'b0);
                check("rst_mid_busy", busy, 1'b0);
                check("rst_mid_txd", eth_txd, 2'b00);
                rst = 1'b0;
                exp_id = 16'h0;
                fin = 1;
            end
            if (done) begin
                done_cyc = cyc;
                fin = 1;
            end
        end
        if (rst_at < 0) begin
            check("done_seen", done_cyc >= 0, 1'b1);
            if (done_cyc >= 0) exp_id = exp_id + 16'd1;
        end
    endtask

    task automatic check_frame(input string tag, input int nw);
        int bad;
        check({tag, "_txen_cycles"}, txen_cnt, ed.size());
        check({tag, "_latency"}, txen_first, 3);
        check({tag, "_done_gap"}, done_cyc - txen_last, IFG_CYCLES);
        bad = (cap.size() < ed.size()) ? ed.size() - cap.size() : 0;
        for (int i = 0; i < cap.size(); i++) if (i >= ed.size() || cap[i] !== ed[i]) bad++;
        check({tag, "_stream_errs"}, bad, 0);
        check({tag, "_idle_txd"}, idle_txd_bad, 0);
        check({tag, "_busy_low"}, busy_low, 0);
        check({tag, "_req_count"}, req_pos.size(), nw);
        bad = 0;
        foreach (req_pos[i]) if (req_pos[i] != 199 + 8 * i) bad++;
        check({tag, "_req_pos_errs"}, bad, 0);
        rb.delete();
        for (int i = 0; i + 3 < cap.size(); i += 4)
            rb.push_back({cap[i+3], cap[i+2], cap[i+1], cap[i]});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_id = 16'h0;
    endtask

    initial begin
        int nz;
        rst = 1'b1; start = 1'b0; payload_words = 11'd0; axiid = 16'h0; axiiv = 1'b0;
        src_mac = {16'($urandom), $urandom}; dst_mac = {16'($urandom), $urandom};
        src_port = 16'($urandom); dst_port = 16'($urandom);
        src_ip = 32'h0A000001; dst_ip = 32'h0A000002;
        exp_id = 16'h0;
        repeat (3) @(negedge clk);
        check("reset_txen", eth_txen, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_txd", eth_txd, 2'b00);
        check("idle_done", done, 1'b0);
        check("idle_axiir", axiir, 1'b0);
        check("idle_underrun", underrun, 1'b0);

        run_frame(11'd9, -1, 1'b0, -1);
        check_frame("w9", 9);
        check("w9_total_len", field16(16), 16'h002E);
        check("w9_ip_csum", field16(24), 16'h26BD);
        check("w9_txen_288", txen_cnt, 288);
        check("w9_underrun", underrun, 1'b0);

        do_reset();
        run_frame(11'd0, -1, 1'b0, -1);
        check_frame("w0", 0);
        check("w0_total_len", field16(16), 16'h001C);
        check("w0_ip_csum", field16(24), 16'h26CF);
        check("w0_udp_len", field16(38), 16'h0008);
        check("w0_txen_288", txen_cnt, 288);
        nz = 0;
        for (int i = 42; i < 60; i++) if (8 + i >= rb.size() || rb[8 + i] !== 8'h00) nz++;
        check("w0_pad_nonzero", nz, 0);

        src_ip = $urandom; dst_ip = $urandom;
        src_mac = {16'($urandom), $urandom}; dst_mac = {16'($urandom), $urandom};
        run_frame(11'd100, 4, 1'b0, -1);
        check_frame("w100", 100);
        check("w100_word5", field16(50), 16'h0000);
        check("w100_underrun", underrun, 1'b1);
        check("w100_txen", txen_cnt, 1016);

        run_frame(11'($urandom_range(1, 30)), -1, 1'b0, -1);
        check_frame("rnd", req_pos.size());
        check("rnd_underrun_clear", ur_at_start, 0);

        do_reset();
        run_frame(11'd5, -1, 1'b1, -1);
        check_frame("b2b_a", 5);
        check("b2b_a_id", field16(18), 16'h0000);
        run_frame(11'd5, -1, 1'b1, -1);
        start = 1'b0;
        check_frame("b2b_b", 5);
        check("b2b_b_id", field16(18), 16'h0001);
        check("b2b_gap_waited", gap_waited, 1);
        check("b2b_gap_busy", gap_busy, 0);

        @(negedge clk);
        run_frame(11'd20, -1, 1'b0, 230);
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        run_frame(11'd3, -1, 1'b0, -1);
        check_frame("after_rst", 3);
        check("after_rst_id", field16(18), 16'h0000);

        src_port = 16'($urandom); dst_port = 16'($urandom);
        run_frame(11'd2047, -1, 1'b0, -1);
        check_frame("clamp", 736);
        check("clamp_total_len", field16(16), 16'h05DC);
        check("clamp_txen", txen_cnt, 6104);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/network_stack_tx.md
Name: network_stack_tx

Overview:
- Transmit counterpart of the RMII receive stack.
- Builds a complete Ethernet II / IPv4 / UDP frame around a caller-supplied payload of 16-bit words and serialises it onto the 2-bit RMII transmit interface.
- Frame order: preamble, SFD, headers, payload, pad, FCS, then interframe gap.
- Sits between the application data source and the PHY TX pins; runs on the 50 MHz RMII reference clock, one dibit per cycle.

Parameters:
- N, 2, RMII data width in bits (only 2 supported).
- MAX_WORDS, 736, maximum payload words per frame (1472 bytes).
- TTL, 8'h40, IPv4 time-to-live.
- IFG_CYCLES, 48, idle cycles after the FCS (12 bytes).

Ports:
- clk  in  1  50 MHz RMII reference clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a frame; sampled only when busy=0.
- payload_words  in  11  payload length in 16-bit words; latched on start.
- src_mac  in  48  source MAC address.
- dst_mac  in  48  destination MAC address.
- src_ip  in  32  source IPv4 address.
- dst_ip  in  32  destination IPv4 address.
- src_port  in  16  UDP source port.
- dst_port  in  16  UDP destination port.
- axiid  in  16  payload word; high byte is sent first.
- axiiv  in  1  payload word valid.
- axiir  out  1  payload word ready; a transfer occurs when axiiv && axiir.
- eth_txd  out  2  RMII transmit dibit.
- eth_txen  out  1  RMII transmit enable.
- busy  out  1  high from start acceptance through the end of the IFG.
- done  out  1  one-cycle pulse on the last IFG cycle.
- underrun  out  1  sticky flag; cleared on the next accepted start.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, IP ID counter 0.
- Reset mid-frame: eth_txen is 0 on the next cycle; no partial FCS is sent.
- Start acceptance: start is accepted in IDLE only; start while busy is ignored.
- Latched on start: all address and port inputs, and payload_words clamped to MAX_WORDS.
- Length fields:
  - L = 2 × payload_words bytes.
  - IP total length = 28 + L.
  - UDP length = 8 + L.
- States: IDLE -> CSUM (2 cycles) -> PREAMBLE -> SFD -> ETH_HDR -> IP_HDR -> UDP_HDR -> PAYLOAD -> PAD -> FCS -> IFG -> IDLE.
- Latency: eth_txen rises on the 3rd cycle after the start cycle.
- Byte serialisation:
  - Each byte occupies 4 cycles, LSB dibit first (byte[1:0] first).
  - Multi-byte fields are sent big-endian.
- PREAMBLE: 7 bytes of 0x55. SFD: 0xD5.
- ETH_HDR (14 bytes): dst_mac, src_mac, ethertype 0x0800.
- IP_HDR (20 bytes), in order:
  - 0x45, 0x00, total length.
  - ID counter; it increments after each completed frame and wraps 0xFFFF -> 0.
  - 0x4000 (DF), TTL, 0x11, header checksum, src_ip, dst_ip.
- Header checksum: ones'-complement of the ones'-complement sum of the ten header halfwords (checksum field taken as 0). It is computed in CSUM with end-around carry folded twice.
- UDP_HDR (8 bytes): src_port, dst_port, UDP length, checksum 0x0000.
- PAYLOAD and the ready handshake:
  - axiir pulses high for one cycle in the cycle before each word's first dibit.
  - If axiiv is low in that cycle, the word is sent as 0x0000, underrun is set, and the frame continues (no stall).
  - axiir is never high outside PAYLOAD.
- PAD: if L < 18, append 18 − L zero bytes. Pad bytes are covered by the FCS but excluded from both length fields.
- FCS: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) over dst_mac through the last pad byte. The complemented remainder is sent LSB first (4 bytes).
- Minimum frame: 64 bytes from dst_mac through the FCS.
- IFG: eth_txen=0 and eth_txd=0 for IFG_CYCLES; busy stays high; done pulses on the final cycle.
- Outside frames, eth_txd is always 2'b00.
- payload_words=0 is legal: the frame carries only headers plus 18 pad bytes.

Decomposition:
- Package eth_tx_pkg holds:
  - the tx_state_t enum;
  - constants ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'h11, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, MIN_PAYLOAD_BYTES=18, CRC_INIT=32'hFFFFFFFF.
- Sub-module crc32_dibit:
  - Inputs: clk, rst, clear, dibit, valid. Output: crc [31:0].
  - One dibit per cycle, reflected update; reused by the receive-side FCS check.

Test Plan:
- src_ip=0x0A000001, dst_ip=0x0A000002, payload_words=9 with axiiv held high:
  - IP total length 0x002E and checksum 0x26BD; no pad.
  - eth_txen high for exactly 288 cycles; FCS matches the model; done pulses 48 cycles after txen falls.
- Same addresses, payload_words=0:
  - IP total length 0x001C, checksum 0x26CF, UDP length 0x0008.
  - 18 zero pad bytes; eth_txen high for 288 cycles.
- payload_words=100, axiiv low for the 5th word request:
  - Word 5 is sent as 0x0000 and underrun goes 1; the frame length is unchanged.
  - underrun clears on the next start.
- Two back-to-back frames with start held high:
  - The second frame begins only after done.
  - The IP ID field reads 0x0000 then 0x0001.
- rst asserted during PAYLOAD:
  - eth_txen=0 the next cycle; busy=0.
  - The next frame's ID is 0x0000.
- payload_words=2047: clamped to 736; IP total length 0x05DC (1500).
